// File: rtl/fsm_timer_pkg.sv
// Shared constants and helpers for the delay-timer datapath.
//   TICKS_DEFAULT   : default clk cycles per delay unit
//   DELAY_W_DEFAULT : default width of the serially loaded delay field
//   presc_w()       : prescaler width for a given ticks-per-unit value
package fsm_timer_pkg;
  localparam int TICKS_DEFAULT   = 1000;
  localparam int DELAY_W_DEFAULT = 4;

  // Smallest width that can hold 0..ticks-1. The guard keeps the width at
  // least 1 bit.
  function automatic int presc_w(input int ticks);
    return (ticks < 2) ? 1 : $clog2(ticks);
  endfunction
endpackage

// File: rtl/fsm_timer_datapath_unit_tick_counter.sv
// unit_tick_counter: mod-N prescaler.
//   clk   : clock
//   reset : synchronous active-high reset
//   clr   : synchronous clear to 0 (wins over en)
//   en    : advance one step; N-1 wraps to 0
//   cnt   : current count
//   tc    : terminal count, combinational (cnt == N-1)
module unit_tick_counter #(
  parameter int N = 1000,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  assign tc = (cnt == W'(N - 1));

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (en)
      cnt <= tc ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/fsm_timer_datapath.sv
// fsm_timer_datapath: delay load/countdown datapath driven by an upstream
// one-hot FSM. It holds no sequencing state of its own.
//   clk           : clock
//   reset         : synchronous active-high reset
//   d             : serial delay bit, MSB first
//   shift_ena     : shift d into the delay register
//   counting      : FSM is in Count; advance the timer
//   done_counting : combinational, high in the last cycle of the interval
//   count         : remaining delay units (the delay register itself)
module fsm_timer_datapath
  import fsm_timer_pkg::*;
#(
  parameter int TICKS_PER_UNIT = TICKS_DEFAULT,
  parameter int DELAY_W        = DELAY_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               d,
  input  logic               shift_ena,
  input  logic               counting,
  output logic               done_counting,
  output logic [DELAY_W-1:0] count
);
  localparam int PW = presc_w(TICKS_PER_UNIT);

  logic [DELAY_W-1:0] delay;
  logic [PW-1:0]      presc;
  logic               presc_tc;
  logic               adv;

  // A shift always wins over counting, so a collision is shift-only.
  assign adv = counting & ~shift_ena;

  unit_tick_counter #(
    .N (TICKS_PER_UNIT),
    .W (PW)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .clr   (shift_ena),
    .en    (adv),
    .cnt   (presc),
    .tc    (presc_tc)
  );

  always_ff @(posedge clk) begin
    if (reset)
      delay <= '0;
    else if (shift_ena)
      delay <= {delay[DELAY_W-2:0], d};
    else if (adv && presc_tc && (delay != '0))
      delay <= delay - 1'b1;
  end

  // The last unit is spent with delay already at 0, which gives the
  // (loaded+1) units of total interval. Reset masks a pending terminal tick.
  assign done_counting = ~reset & adv & presc_tc & (delay == '0);
  assign count         = delay;
endmodule

// File: doc/fsm_timer_datapath.md
FSM_TIMER_DATAPATH -- requirements
Module: fsm_timer_datapath

Interface
REQ-001 Parameter TICKS_PER_UNIT, default 1000, is the number of clk cycles per delay unit; legal range is 2 to 65535.
REQ-002 Parameter DELAY_W, default 4, is the width of the delay field shifted in serially.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 d  input  1  serial data bit; it is the same bit stream the pattern-detect FSM sees.
REQ-006 shift_ena  input  1  shift d into the delay register this cycle.
REQ-007 counting  input  1  FSM is in Count; advance the timer this cycle.
REQ-008 done_counting  output  1  combinational; high in the final cycle of the timed interval.
REQ-009 count  output  DELAY_W  current remaining delay units, i.e. the delay register.

Function
REQ-010 The delay register SHALL shift in MSB first on each cycle with shift_ena=1: delay <= {delay[DELAY_W-2:0], d}.
REQ-011 Each cycle with shift_ena=1 SHALL clear the prescaler to 0.
REQ-012 A cycle with counting=1 and shift_ena=0 SHALL increment the prescaler, and TICKS_PER_UNIT-1 SHALL wrap to 0.
REQ-013 On a prescaler wrap with delay!=0, delay SHALL decrement by 1; with delay==0, delay SHALL hold at 0 (no underflow).
REQ-014 done_counting SHALL equal counting & ~shift_ena & (delay==0) & (prescaler==TICKS_PER_UNIT-1), combinationally, with zero-cycle latency.
REQ-015 Counting time from the first counting cycle to the done_counting cycle inclusive SHALL be (loaded_delay+1)*TICKS_PER_UNIT cycles.
REQ-016 Cycles with shift_ena=0 and counting=0 SHALL hold delay and prescaler unchanged (pause/resume is seamless).
REQ-017 shift_ena=1 together with counting=1 is not legal from the FSM; the block SHALL treat it as shift only, with done_counting=0.
REQ-018 After done_counting, the prescaler SHALL be 0 and delay 0; continued counting SHALL repeat done_counting every TICKS_PER_UNIT cycles.
REQ-019 count SHALL be driven directly from the delay register, with no extra latency.

Reset
REQ-020 reset=1 at a clock edge SHALL set delay=0 and prescaler=0, overriding shift_ena and counting.
REQ-021 While reset=1, done_counting SHALL be 0 regardless of counting.
REQ-022 Reset mid-count SHALL abandon the interval; the next counting run then lasts TICKS_PER_UNIT cycles unless a reload occurs first.

Structure
REQ-023 Shared package fsm_timer_pkg SHALL hold the default constants TICKS_DEFAULT=1000 and DELAY_W_DEFAULT=4.
REQ-024 The package SHALL also hold the function computing the prescaler width as clog2(TICKS_PER_UNIT).
REQ-025 The prescaler SHALL be the sub-module unit_tick_counter, a mod-N counter with clear and enable ports and a terminal-count output.
REQ-026 The delay register and the decrement logic SHALL remain in fsm_timer_datapath.
REQ-027 The block SHALL contain no FSM state; sequencing is owned by the upstream one-hot FSM.

Verification (defaults TICKS_PER_UNIT=1000, DELAY_W=4)
REQ-028 Load: shift_ena=1 for 4 cycles with d=0,0,1,0 -> count=2 after the 4th edge.
REQ-029 Count from 2: counting held high -> count=1 after 1000 cycles and 0 after 2000; done_counting high only in cycle 3000.
REQ-030 delay=0: counting held high -> done_counting in cycle 1000; with delay=15 -> done_counting in cycle 16000.
REQ-031 Pause: counting low for 37 cycles mid-interval -> done_counting delayed by exactly 37 cycles; count is frozen during the pause.
REQ-032 Collision: shift_ena=1 and counting=1 in the same cycle -> shift occurs, prescaler=0, done_counting=0.
REQ-033 Reset: reset=1 for one cycle mid-count with count=3 -> count=0, prescaler=0; a following counting run ends in cycle 1000.
